dcache_evict_buffer: RTL and testbench

Write-back eviction buffer between the L1 data cache's physical-memory port and physical memory. Absorbs dirty-line write-backs from the L1 dcache in one handshake, drains them to pmem when the memory port is otherwise idle, and services L1 line-fill reads. Fills are served from buffered lines on an address match and forwarded to pmem otherwise. Upstream it presents the same read/write/resp/128-bit line protocol that pmem presents.

---
 rtl/dcache_evict_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_evict_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_evict_buffer.sv
// Write-back eviction buffer between the L1 dcache and pmem: absorbs dirty lines,
// drains them when idle, and serves fills. Define DCACHE_EVICT_COALESCE_EN to merge same-tag writes.
module dcache_evict_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  l1_address,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [127:0] l1_wdata,
    output logic         l1_resp,
    output logic [127:0] l1_rdata,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RESP, READ_MEM, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [11:0]      tag_reg  [DEPTH];
    logic [127:0]     data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic         l1_resp_reg;
    logic [127:0] l1_rdata_reg;
    logic [15:0]  pmem_address_reg;
    logic         pmem_read_reg;
    logic         pmem_write_reg;
    logic [127:0] pmem_wdata_reg;

    logic [11:0]      req_tag;
    logic [DEPTH-1:0] match_vec;
    logic [PTR_W-1:0] age_idx [DEPTH];
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             coalesce_hit;
    logic             full;
    logic [PTR_W-1:0] rd_idx;

    logic do_push, do_overwrite, do_pop, do_hit, do_fill, start_read, start_drain;

    assign req_tag = l1_address[15:4];
    assign full    = (count_reg == FULL_COUNT);

    // age_idx[k] is the slot written k+1 pushes ago, so age 0 is the youngest entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_vec[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
            assign age_idx[gi]   = tail_reg - PTR_W'(gi + 1);
        end
    endgenerate

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            if (match_vec[age_idx[a]]) begin
                hit     = 1'b1;
                hit_idx = age_idx[a];
            end
        end
    end

`ifdef DCACHE_EVICT_COALESCE_EN
    assign coalesce_hit = hit;
`else
    assign coalesce_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        do_push      = 1'b0;
        do_overwrite = 1'b0;
        do_pop       = 1'b0;
        do_hit       = 1'b0;
        do_fill      = 1'b0;
        start_read   = 1'b0;
        start_drain  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (l1_write) begin
                    if (coalesce_hit) begin
                        do_overwrite = 1'b1;
                        state_next   = RESP;
                    end else if (!full) begin
                        do_push    = 1'b1;
                        state_next = RESP;
                    end else begin
                        start_drain = 1'b1;
                        state_next  = DRAIN;
                    end
                end else if (l1_read) begin
                    if (hit) begin
                        do_hit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        start_read = 1'b1;
                        state_next = READ_MEM;
                    end
                end else if (count_reg != '0) begin
                    start_drain = 1'b1;
                    state_next  = DRAIN;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            READ_MEM: begin
                if (pmem_resp) begin
                    do_fill    = 1'b1;
                    state_next = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    do_pop     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Hits and drains never start in the same cycle, so one read port serves both.
    assign rd_idx = start_drain ? head_reg : hit_idx;

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[tail_reg] <= l1_wdata;
            tag_reg[tail_reg]  <= req_tag;
        end else if (do_overwrite) begin
            data_mem[hit_idx] <= l1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg        <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            l1_resp_reg      <= 1'b0;
            l1_rdata_reg     <= '0;
            pmem_address_reg <= '0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_wdata_reg   <= '0;
        end else begin
            l1_resp_reg <= (state_next == RESP);
            if (do_push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
                count_reg           <= count_reg + CNT_W'(1);
            end
            if (do_pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
                count_reg           <= count_reg - CNT_W'(1);
                pmem_write_reg      <= 1'b0;
            end
            if (do_hit) begin
                l1_rdata_reg <= data_mem[rd_idx];
            end
            if (do_fill) begin
                l1_rdata_reg  <= pmem_rdata;
                pmem_read_reg <= 1'b0;
            end
            if (start_read) begin
                pmem_read_reg    <= 1'b1;
                pmem_address_reg <= {req_tag, 4'b0000};
            end
            if (start_drain) begin
                pmem_write_reg   <= 1'b1;
                pmem_address_reg <= {tag_reg[head_reg], 4'b0000};
                pmem_wdata_reg   <= data_mem[rd_idx];
            end
        end
    end

    assign l1_resp      = l1_resp_reg;
    assign l1_rdata     = l1_rdata_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_wdata   = pmem_wdata_reg;

endmodule

// File: tb/tb_dcache_evict_buffer.sv
// Bench for dcache_evict_buffer: a memory-coherence model (latest value per line plus an
// ordered list of buffered lines) checked every cycle, with directed latency checks.
module tb_dcache_evict_buffer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  l1_address = '0;
    logic         l1_read = 1'b0;
    logic         l1_write = 1'b0;
    logic [127:0] l1_wdata = '0;
    logic         l1_resp;
    logic [127:0] l1_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    always #5 clk = ~clk;

    dcache_evict_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .l1_address(l1_address), .l1_read(l1_read), .l1_write(l1_write), .l1_wdata(l1_wdata),
        .l1_resp(l1_resp), .l1_rdata(l1_rdata),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct { logic [11:0] tag; logic [127:0] data; } ent_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ent_t         mq[$];                  // lines held in the buffer, oldest first
    logic [127:0] gm[logic [11:0]];       // newest value of each line not yet known to be in pmem
    logic [127:0] pmem_mem[logic [11:0]];
    logic [127:0] drain_log[$];

    logic         cur_is_wr = 1'b0;
    logic [15:0]  cur_addr = '0;
    logic [127:0] cur_data = '0;

    logic         pmem_hold = 1'b0;
    int           pmem_lat = 1;
    int           wait_cnt = 0;

    int           drain_cnt = 0, rd_rise_cnt = 0;
    int           last_ack_cyc = 0, last_fill_cyc = 0, last_resp_cyc = 0;
    logic [15:0]  last_drain_addr = '0, last_rd_addr = '0;

    int           lat;
    logic [127:0] rd;
    int           d0, r0, cnt;

    function automatic logic [127:0] dflt(input logic [11:0] t);
        return {8{t, 4'hA}};
    endfunction

    function automatic logic [127:0] pm_read(input logic [11:0] t);
        return pmem_mem.exists(t) ? pmem_mem[t] : dflt(t);
    endfunction

    function automatic logic [127:0] sys_read(input logic [11:0] t);
        return gm.exists(t) ? gm[t] : pm_read(t);
    endfunction

    function automatic bit buffered(input logic [11:0] t);
        foreach (mq[k]) if (mq[k].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // pmem responder: answers after pmem_lat waiting cycles unless held off
    initial forever begin
        @(posedge clk);
        #1;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            wait_cnt  = 0;
        end else if (pmem_read || pmem_write) begin
            if (!pmem_hold && wait_cnt >= pmem_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = pmem_read ? pm_read(pmem_address[15:4]) : '0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Compare process: checks the DUT against the model on every cycle
    initial begin
        logic         prev_rd, prev_wr, prev_resp, prev_rst, prev_l1_resp;
        logic [15:0]  prev_addr;
        logic [127:0] prev_wdata;
        ent_t         e;
        bit           found;
        prev_rd = 0; prev_wr = 0; prev_resp = 0; prev_rst = 1; prev_l1_resp = 0;
        prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("rd_wr_exclusive", pmem_read && pmem_write, 1'b0);
                if (pmem_read || pmem_write) chk("pmem_addr_aligned", pmem_address[3:0], 4'h0);
                if ((prev_rd || prev_wr) && !prev_resp && !prev_rst) begin
                    chk("pmem_req_held", {pmem_read, pmem_write}, {prev_rd, prev_wr});
                    chk("pmem_addr_stable", pmem_address, prev_addr);
                    if (prev_wr) chk("pmem_wdata_stable", pmem_wdata, prev_wdata);
                end
                if (pmem_read && !prev_rd) begin
                    rd_rise_cnt++;
                    last_rd_addr = pmem_address;
                    chk("fill_addr", pmem_address, {cur_addr[15:4], 4'h0});
                    chk("fill_not_buffered", buffered(cur_addr[15:4]), 1'b0);
                end
                if (pmem_resp && pmem_write) begin
                    n_cmp++;
                    if (mq.size() == 0) begin
                        n_bad++;
                        $display("FAIL drain_expected: got drain of %h, expected empty buffer", pmem_address);
                    end else begin
                        e = mq.pop_front();
                        chk("drain_addr", pmem_address, {e.tag, 4'h0});
                        chk("drain_data", pmem_wdata, e.data);
                    end
                    pmem_mem[pmem_address[15:4]] = pmem_wdata;
                    drain_log.push_back(pmem_wdata);
                    drain_cnt++;
                    last_ack_cyc    = cyc;
                    last_drain_addr = pmem_address;
                end
                if (pmem_resp && pmem_read) last_fill_cyc = cyc;
                if (l1_resp) begin
                    last_resp_cyc = cyc;
                    chk("l1_resp_one_cycle", prev_l1_resp, 1'b0);
                    if (cur_is_wr) begin
                        e.tag  = cur_addr[15:4];
                        e.data = cur_data;
                        found  = 1'b0;
`ifdef DCACHE_EVICT_COALESCE_EN
                        foreach (mq[k]) if (mq[k].tag == e.tag) begin
                            mq[k].data = e.data;
                            found = 1'b1;
                        end
`endif
                        if (!found) mq.push_back(e);
                        gm[e.tag] = e.data;
                    end else begin
                        chk("fill_data", l1_rdata, sys_read(cur_addr[15:4]));
                    end
                end
            end
            prev_rd = pmem_read; prev_wr = pmem_write; prev_resp = pmem_resp;
            prev_addr = pmem_address; prev_wdata = pmem_wdata;
            prev_rst = reset; prev_l1_resp = l1_resp;
        end
    end

    task automatic l1_do(input logic wr, input logic [15:0] addr, input logic [127:0] data,
                         output int lat_o, output logic [127:0] rd_o);
        @(posedge clk);
        #1;
        cur_is_wr = wr; cur_addr = addr; cur_data = data;
        l1_address = addr; l1_wdata = data; l1_write = wr; l1_read = !wr;
        lat_o = 0;
        rd_o  = '0;
        while (1) begin
            @(negedge clk);
            lat_o++;
            if (l1_resp) break;
            if (lat_o >= 300) begin
                n_cmp++; n_bad++;
                $display("FAIL l1_timeout: got no l1_resp for %h, expected one within 300 cycles", addr);
                break;
            end
        end
        rd_o = l1_rdata;
        l1_read = 1'b0;
        l1_write = 1'b0;
        $display("txn %s addr=%h data=%h latency=%0d", wr ? "WR" : "RD", addr, wr ? data : rd_o, lat_o);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((mq.size() != 0 || pmem_read || pmem_write) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("buffer_drained", mq.size() == 0 && !pmem_read && !pmem_write, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] D1 = 128'hD1D1_0001_0002_0003_0004_0005_0006_0007;
    localparam logic [127:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] D3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] D4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [127:0] D6 = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
    localparam logic [127:0] D7 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    localparam logic [127:0] D8 = 128'h8888_8888_0000_0000_8888_8888_0000_0000;

    logic        op_wr   [12] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    logic [15:0] op_addr [12] = '{16'h8000, 16'h9000, 16'h8004, 16'h8000, 16'hA000, 16'h9000,
                                  16'hA00C, 16'hB000, 16'h9000, 16'h9008, 16'h8000, 16'hC000};

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_l1_resp", l1_resp, 1'b0);
        chk("reset_l1_rdata", l1_rdata, '0);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);
        chk("reset_pmem_address", pmem_address, '0);
        chk("reset_pmem_wdata", pmem_wdata, '0);

        // single write, then automatic drain
        pmem_lat = 1;
        d0 = drain_cnt;
        l1_do(1'b1, 16'h1230, D0, lat, rd);
        chk("write_latency", lat, 2);
        wait_quiet();
        chk("drain_count_1", drain_cnt - d0, 1);
        chk("drain_addr_1230", last_drain_addr, 16'h1230);
        chk("drain_data_d0", drain_log[drain_log.size() - 1], D0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (pmem_write) cnt++;
        end
        chk("no_drain_when_empty", cnt, 0);

        // read hit before the drain starts
        l1_do(1'b1, 16'h1000, D1, lat, rd);
        r0 = rd_rise_cnt;
        l1_do(1'b0, 16'h100A, '0, lat, rd);
        chk("hit_latency", lat, 2);
        chk("hit_data", rd, D1);
        chk("hit_no_pmem_read", rd_rise_cnt - r0, 0);
        wait_quiet();

        // full buffer: write waits for one drain
        pmem_hold = 1'b1;
        l1_do(1'b1, 16'h2000, D2, lat, rd);
        chk("fill0_latency", lat, 2);
        l1_do(1'b1, 16'h3000, D3, lat, rd);
        chk("fill1_latency", lat, 2);
        fork
            l1_do(1'b1, 16'h4000, D4, lat, rd);
            begin
                repeat (6) @(negedge clk);
                chk("full_drain_active", pmem_write, 1'b1);
                chk("full_drain_addr", pmem_address, 16'h2000);
                chk("full_no_resp_yet", l1_resp, 1'b0);
                pmem_hold = 1'b0;
            end
        join
        chk("full_resp_after_drain", last_resp_cyc - last_ack_cyc, 2);
        chk("full_drained_oldest", last_drain_addr, 16'h2000);
        wait_quiet();
        chk("full_last_drain_d4", drain_log[drain_log.size() - 1], D4);

        // read miss goes to pmem
        pmem_mem[12'h555] = D5;
        pmem_lat = 2;
        r0 = rd_rise_cnt;
        l1_do(1'b0, 16'h5550, '0, lat, rd);
        chk("miss_latency", lat, 5);
        chk("miss_data", rd, D5);
        chk("miss_pmem_addr", last_rd_addr, 16'h5550);
        chk("miss_one_pmem_read", rd_rise_cnt - r0, 1);
        chk("miss_resp_after_fill", last_resp_cyc - last_fill_cyc, 1);
        pmem_lat = 1;

        // same-tag writes
        pmem_hold = 1'b1;
        l1_do(1'b1, 16'h6000, D6, lat, rd);
        chk("dup0_latency", lat, 2);
        l1_do(1'b1, 16'h6000, D7, lat, rd);
        chk("dup1_latency", lat, 2);
        l1_do(1'b0, 16'h6000, '0, lat, rd);
        chk("dup_read_latency", lat, 2);
        chk("dup_read_newest", rd, D7);
        d0 = drain_cnt;
        pmem_hold = 1'b0;
        wait_quiet();
`ifdef DCACHE_EVICT_COALESCE_EN
        chk("dup_drain_count", drain_cnt - d0, 1);
        chk("dup_drain_d7", drain_log[drain_log.size() - 1], D7);
`else
        chk("dup_drain_count", drain_cnt - d0, 2);
        chk("dup_drain_first_d6", drain_log[drain_log.size() - 2], D6);
        chk("dup_drain_second_d7", drain_log[drain_log.size() - 1], D7);
`endif

        // reset during a drain discards the buffer
        pmem_hold = 1'b1;
        l1_do(1'b1, 16'h7000, D8, lat, rd);
        cnt = 0;
        while (!pmem_write && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_drain_started", pmem_write, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        mq.delete();
        gm.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pmem_write_low", pmem_write, 1'b0);
        chk("rst_pmem_read_low", pmem_read, 1'b0);
        chk("rst_l1_resp_low", l1_resp, 1'b0);
        pmem_hold = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (pmem_write) cnt++;
        end
        chk("rst_buffer_empty", cnt, 0);
        r0 = rd_rise_cnt;
        l1_do(1'b0, 16'h7000, '0, lat, rd);
        chk("rst_entry_lost", rd, {8{16'h700A}});
        chk("rst_read_is_miss", rd_rise_cnt - r0, 1);

        // mixed traffic with varying idle gaps
        for (int i = 0; i < 12; i++) begin
            l1_do(op_wr[i], op_addr[i], {8{op_addr[i] ^ 16'(i)}}, lat, rd);
            repeat (i % 4) @(negedge clk);
        end
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of test, expected finish before 400000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
